four_bit_spi: RTL and testbench

- Serial-port master for the AD9958 DDS controller. Shifts up to 63 bits of a 64-bit word out over an SPI-like bus.
- Two modes: single-bit (sdio[0]) or four-bit parallel (sdio[3:0], AD9958 4-bit serial mode).
- Chip-select, serial clock and data are generated from the system clock.
- Started by a trigger pulse; reports activity on busy.

---
 rtl/four_bit_spi.sv | 124 ++++++++++++
 tb/tb_four_bit_spi.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/four_bit_spi.sv
// AD9958 serial-port master: shifts up to 63 payload bits out in 1-bit or 4-bit mode.
// Define LSB_FIRST_EN to send symbols least-significant first instead of MSB first.
module four_bit_spi #(
  parameter int unsigned SCLK_HALF = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        trigger,
  input  logic        four_bit,
  input  logic [5:0]  bits_to_send,
  input  logic [63:0] data_input,
  output logic        busy,
  output logic        cs,
  output logic        sclk,
  output logic [3:0]  sdio
);

  localparam int unsigned CW = $clog2(SCLK_HALF + 1);
  localparam logic [CW-1:0] LastCnt = CW'(SCLK_HALF - 1);

  typedef enum logic [1:0] {StIdle, StLow, StHigh, StTail} state_e;

  state_e        r_state, w_state_next;
  logic [CW-1:0] r_cnt, w_cnt_next;
  logic [6:0]    r_left, w_left_next;
  logic [63:0]   r_shift, w_shift_next;
  logic          r_four, w_four_next;

  logic          w_last_tick;
  logic [6:0]    w_syms;
  logic [63:0]   w_load;
  logic [63:0]   w_step;
  logic [3:0]    w_sym;

  assign w_last_tick = (r_cnt == LastCnt);
  assign w_syms      = four_bit ? (({1'b0, bits_to_send} + 7'd3) >> 2) : {1'b0, bits_to_send};

`ifdef LSB_FIRST_EN
  // Mask off bits above the payload so padding of the top symbol reads as zero.
  assign w_load = data_input & ~({64{1'b1}} << bits_to_send);
  assign w_step = r_four ? (r_shift >> 4) : (r_shift >> 1);
  assign w_sym  = r_four ? r_shift[3:0] : {3'b000, r_shift[0]};
`else
  // Left-align the payload; zeros shift in below bit 0 as padding.
  assign w_load = data_input << (7'd64 - {1'b0, bits_to_send});
  assign w_step = r_four ? (r_shift << 4) : (r_shift << 1);
  assign w_sym  = r_four ? r_shift[63:60] : {3'b000, r_shift[63]};
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_left  <= '0;
      r_shift <= '0;
      r_four  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_left  <= w_left_next;
      r_shift <= w_shift_next;
      r_four  <= w_four_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_left_next  = r_left;
    w_shift_next = r_shift;
    w_four_next  = r_four;
    busy         = 1'b1;
    cs           = 1'b0;
    sclk         = 1'b0;
    sdio         = w_sym;
    unique case (r_state)
      StIdle: begin
        busy = 1'b0;
        cs   = 1'b1;
        sdio = 4'h0;
        if (trigger && (bits_to_send != 6'd0)) begin
          w_state_next = StLow;
          w_cnt_next   = '0;
          w_left_next  = w_syms;
          w_shift_next = w_load;
          w_four_next  = four_bit;
        end
      end
      StLow: begin
        if (w_last_tick) begin
          w_state_next = StHigh;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + CW'(1);
        end
      end
      StHigh: begin
        sclk = 1'b1;
        if (w_last_tick) begin
          w_cnt_next = '0;
          if (r_left == 7'd1) begin
            w_state_next = StTail;
          end else begin
            w_state_next = StLow;
            w_shift_next = w_step;
            w_left_next  = r_left - 7'd1;
          end
        end else begin
          w_cnt_next = r_cnt + CW'(1);
        end
      end
      StTail: begin
        if (w_last_tick) begin
          w_state_next = StIdle;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + CW'(1);
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

endmodule

// File: tb/tb_four_bit_spi.sv
// Scoreboard bench for four_bit_spi: stimulus queues expected symbols and transfer lengths,
// a negedge monitor compares each sampled symbol and each completed transfer.
module tb_four_bit_spi;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        trigger = 1'b0;
  logic        four_bit = 1'b0;
  logic [5:0]  bits_to_send = '0;
  logic [63:0] data_input = '0;
  logic        busy, cs, sclk;
  logic [3:0]  sdio;

  always #5 clock = ~clock;

  four_bit_spi #(.SCLK_HALF(2)) dut (
    .clock        (clock),
    .reset        (reset),
    .trigger      (trigger),
    .four_bit     (four_bit),
    .bits_to_send (bits_to_send),
    .data_input   (data_input),
    .busy         (busy),
    .cs           (cs),
    .sclk         (sclk),
    .sdio         (sdio)
  );

  typedef struct {
    int edges;
    int len;
  } xfer_t;

  logic [3:0] sym_q[$];
  xfer_t      len_q[$];

  int   checks = 0;
  int   failures = 0;
  int   mon_xfers = 0;
  int   cur_edges = 0;
  int   busy_cnt = 0;
  int   cs_bad = 0;
  int   idle_bad = 0;
  bit   aborting = 1'b0;
  logic prev_sclk = 1'b0;
  logic prev_busy = 1'b0;

  localparam logic [63:0] Data40 = 64'h0000_0098_7654_3210;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic logic [3:0] model(input logic [63:0] d, input int n, input bit four,
                                       input int k);
    logic [3:0] s;
    int idx;
    s = 4'h0;
`ifdef LSB_FIRST_EN
    if (!four) s[0] = d[k];
    else
      for (int j = 0; j < 4; j++) begin
        idx = 4 * k + j;
        if (idx < n) s[j] = d[idx];
      end
`else
    if (!four) s[0] = d[n-1-k];
    else
      for (int j = 0; j < 4; j++) begin
        idx = n - 1 - 4 * k - j;
        if (idx >= 0) s[3-j] = d[idx];
      end
`endif
    return s;
  endfunction

  task automatic push_model(input logic [63:0] d, input int n, input bit four, input int len);
    int s;
    s = four ? (n + 3) / 4 : n;
    for (int k = 0; k < s; k++) sym_q.push_back(model(d, n, four, k));
    len_q.push_back('{s, len});
  endtask

  task automatic fire(input logic [63:0] d, input logic [5:0] n, input bit four);
    @(posedge clock);
    #1;
    data_input   = d;
    bits_to_send = n;
    four_bit     = four;
    trigger      = 1'b1;
    @(posedge clock);
    #1;
    trigger      = 1'b0;
    // Scramble inputs mid-transfer; the latched copy must be used.
    data_input   = ~d;
    bits_to_send = ~n;
    four_bit     = ~four;
  endtask

  task automatic wait_done(input int len);
    for (int i = 0; i < len + 20; i++) begin
      @(posedge clock);
      if (len_q.size() == 0) break;
    end
    check("transfers_pending_after_wait", len_q.size(), 0);
    sym_q.delete();
    len_q.delete();
  endtask

  // Monitor: samples on the falling clock edge, away from the DUT's active edge.
  initial begin
    xfer_t e;
    forever begin
      @(negedge clock);
      if (busy) begin
        busy_cnt++;
        if (cs !== 1'b0) cs_bad++;
        if (sclk && !prev_sclk) begin
          cur_edges++;
          if (sym_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL extra_sclk_edge: edge %0d has no expected symbol", cur_edges);
          end else begin
            check("sdio_symbol", int'(sdio), int'(sym_q.pop_front()));
          end
        end
      end else if (cs !== 1'b1 || sclk !== 1'b0 || sdio !== 4'h0) begin
        idle_bad++;
      end
      if (prev_busy && !busy) begin
        if (aborting) begin
          aborting = 1'b0;
        end else if (len_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_transfer: busy for %0d cycles, none expected", busy_cnt);
        end else begin
          e = len_q.pop_front();
          check("sclk_edges", cur_edges, e.edges);
          check("busy_cycles", busy_cnt, e.len);
          check("cs_low_while_busy", cs_bad, 0);
          mon_xfers++;
        end
        cur_edges = 0;
        busy_cnt  = 0;
        cs_bad    = 0;
      end
      prev_sclk = sclk;
      prev_busy = busy;
    end
  end

  initial begin
    #500_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int x;
    repeat (3) @(posedge clock);
    #1;
    check("reset_busy", int'(busy), 0);
    check("reset_cs", int'(cs), 1);
    check("reset_sclk", int'(sclk), 0);
    check("reset_sdio", int'(sdio), 0);
    reset = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    check("idle_busy", int'(busy), 0);
    check("idle_cs", int'(cs), 1);

    // 40 bits single-bit: 40 edges, (2*40+1)*2 = 162 busy cycles.
    push_model(Data40, 40, 1'b0, 162);
    fire(Data40, 6'd40, 1'b0);
    wait_done(162);

    // 40 bits four-bit: 10 nibbles, (2*10+1)*2 = 42 busy cycles.
    push_model(Data40, 40, 1'b1, 42);
    fire(Data40, 6'd40, 1'b1);
    wait_done(42);

    // 6 bits four-bit with zero padding; payload 6'b101101, upper input bits set.
`ifdef LSB_FIRST_EN
    sym_q.push_back(4'b1101);
    sym_q.push_back(4'b0010);
`else
    sym_q.push_back(4'b1011);
    sym_q.push_back(4'b0100);
`endif
    len_q.push_back('{2, 10});
    fire(64'hFFFF_FFFF_FFFF_FFED, 6'd6, 1'b1);
    wait_done(10);

    // Zero-length request is ignored.
    x = mon_xfers;
    fire(64'hFFFF_FFFF_FFFF_FFFF, 6'd0, 1'b0);
    repeat (10) @(posedge clock);
    #1;
    check("zero_bits_no_transfer", mon_xfers, x);
    check("zero_bits_busy", int'(busy), 0);

    // Trigger held through a transfer: ignored while busy, accepted on first idle cycle.
    x = mon_xfers;
    push_model(64'h0000_0000_0000_00A5, 8, 1'b0, 34);
    push_model(64'h0000_0000_0000_00A5, 8, 1'b0, 34);
    @(posedge clock);
    #1;
    data_input   = 64'h0000_0000_0000_00A5;
    bits_to_send = 6'd8;
    four_bit     = 1'b0;
    trigger      = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock);
      #1;
      if (busy) break;
    end
    check("held_trigger_started", int'(busy), 1);
    for (int i = 0; i < 60; i++) begin
      @(posedge clock);
      #1;
      if (!busy) break;
    end
    check("held_trigger_first_done", int'(busy), 0);
    @(posedge clock);
    #1;
    trigger = 1'b0;
    wait_done(34);
    repeat (5) @(posedge clock);
    #1;
    check("held_trigger_two_transfers", mon_xfers, x + 2);
    check("held_trigger_idle_after", int'(busy), 0);

    // Reset after 5 sclk edges aborts; the next transfer starts clean.
    push_model(Data40, 40, 1'b0, 162);
    fire(Data40, 6'd40, 1'b0);
    for (int i = 0; i < 100; i++) begin
      @(posedge clock);
      #2;
      if (cur_edges >= 5) break;
    end
    check("edges_before_abort", cur_edges, 5);
    aborting = 1'b1;
    reset    = 1'b1;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_cs", int'(cs), 1);
    check("abort_sclk", int'(sclk), 0);
    check("abort_sdio", int'(sdio), 0);
    sym_q.delete();
    len_q.delete();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    push_model(Data40, 40, 1'b1, 42);
    fire(Data40, 6'd40, 1'b1);
    wait_done(42);

    check("idle_outputs_clean", idle_bad, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
